// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
//   Shares one AES core among NUM_REQ requesters. Requests are granted
//   round-robin, one at a time. The granted plaintext and key are latched and
//   held for the core, and a single-cycle start is issued. The ciphertext, or
//   a watchdog error, is then returned on one back-pressured response channel
//   tagged with the requester index.
//
//   Ports
//     iClk, iRst         clock, asynchronous active-high reset
//     iReqValid          per-requester request valid
//     oReqReady          one-hot, 1-cycle grant pulse
//     iReqPlaintext      requester r at [128*r +: 128]
//     iReqKey            requester r at [KEY_SIZE*r +: KEY_SIZE]
//     oCoreStart         start pulse to the core
//     oCorePlaintext     latched plaintext to the core
//     oCoreKey           latched key to the core
//     iCoreCiphertext    core result
//     iCoreDone          core done pulse
//     oRspValid          response valid
//     iRspReady          response accept
//     oRspId             index of the requester being answered
//     oRspCiphertext     result (0 on error)
//     oRspErr            watchdog timeout flag
//     oBusy              high whenever not idle
//     oDoneCount         completed responses, wraps
module aes_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int KEY_SIZE       = 128,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic [NUM_REQ-1:0]           iReqValid,
   output logic [NUM_REQ-1:0]           oReqReady,
   input  logic [NUM_REQ*128-1:0]       iReqPlaintext,
   input  logic [NUM_REQ*KEY_SIZE-1:0]  iReqKey,
   output logic                         oCoreStart,
   output logic [127:0]                 oCorePlaintext,
   output logic [KEY_SIZE-1:0]          oCoreKey,
   input  logic [127:0]                 iCoreCiphertext,
   input  logic                         iCoreDone,
   output logic                         oRspValid,
   input  logic                         iRspReady,
   output logic [ID_W-1:0]              oRspId,
   output logic [127:0]                 oRspCiphertext,
   output logic                         oRspErr,
   output logic                         oBusy,
   output logic [15:0]                  oDoneCount
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       last;      // most recently answered requester
   logic [ID_W-1:0]       id;        // requester currently in flight
   logic [WD_W-1:0]       wd;
   logic                  timeout;

   logic                  any_req;
   logic [NUM_REQ-1:0]    gnt;
   logic [ID_W-1:0]       gnt_id;
   logic [127:0]          gnt_pt;
   logic [KEY_SIZE-1:0]   gnt_key;

   assign timeout = (wd == WD_W'(TIMEOUT_CYCLES - 1));

   // Round-robin pick: scan last+1, last+2, ... and take the first valid one.
   always_comb begin
      any_req = 1'b0;
      gnt     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && iReqValid[i] && ((int'(last) + k) % NUM_REQ) == i) begin
               any_req = 1'b1;
               gnt[i]  = 1'b1;
            end
         end
      end
   end

   // One-hot select of the winner's id and data.
   always_comb begin
      gnt_id  = '0;
      gnt_pt  = '0;
      gnt_key = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_id  = ID_W'(i);
            gnt_pt  = iReqPlaintext[128*i +: 128];
            gnt_key = iReqKey[KEY_SIZE*i +: KEY_SIZE];
         end
      end
   end

   // State register
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; a done in the timeout cycle still counts as success.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req)               state_nxt = S_ISSUE;
         S_ISSUE:                            state_nxt = S_WAIT;
         S_WAIT:  if (iCoreDone || timeout)  state_nxt = S_RESP;
         S_RESP:  if (iRspReady)             state_nxt = S_IDLE;
         default:                            state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs and datapath. Core operands only change on a grant,
   // so they stay stable for the whole core operation.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oReqReady      <= '0;
         oCoreStart     <= 1'b0;
         oCorePlaintext <= '0;
         oCoreKey       <= '0;
         oRspValid      <= 1'b0;
         oRspId         <= '0;
         oRspCiphertext <= '0;
         oRspErr        <= 1'b0;
         oBusy          <= 1'b0;
         oDoneCount     <= '0;
         last           <= ID_W'(NUM_REQ - 1);
         id             <= '0;
         wd             <= '0;
      end else begin
         oReqReady  <= '0;
         oCoreStart <= 1'b0;
         oBusy      <= (state_nxt != S_IDLE);
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  oReqReady      <= gnt;
                  oCorePlaintext <= gnt_pt;
                  oCoreKey       <= gnt_key;
                  id             <= gnt_id;
               end
            end
            S_ISSUE: begin
               oCoreStart <= 1'b1;
               wd         <= '0;
            end
            S_WAIT: begin
               if (iCoreDone) begin
                  oRspValid      <= 1'b1;
                  oRspId         <= id;
                  oRspCiphertext <= iCoreCiphertext;
                  oRspErr        <= 1'b0;
               end else if (timeout) begin
                  oRspValid      <= 1'b1;
                  oRspId         <= id;
                  oRspCiphertext <= '0;
                  oRspErr        <= 1'b1;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            S_RESP: begin
               if (iRspReady) begin
                  oRspValid  <= 1'b0;
                  last       <= id;
                  oDoneCount <= oDoneCount + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
